// File: rtl/sprite_compositor.sv
// Sprite layering engine: double-buffered sprite table, per-sprite ROM addressing,
// colour-key transparency, priority merge over background, and sprite-0 collisions.
module sprite_compositor #(
  parameter int          NUM_SPR = 8,
  parameter int          XW      = 10,
  parameter int          YW      = 9,
  parameter int          ADDR_W  = 14,
  parameter int          ROM_LAT = 1,
  parameter logic [11:0] KEY     = 12'h428
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      frame_start,
  input  logic                      pix_valid_in,
  input  logic [XW-1:0]             col,
  input  logic [YW-1:0]             row,
  input  logic                      wr_en,
  input  logic [3:0]                wr_idx,
  input  logic [XW-1:0]             wr_x,
  input  logic [YW-1:0]             wr_y,
  input  logic [5:0]                wr_w,
  input  logic [5:0]                wr_h,
  input  logic                      wr_vis,
  output logic [NUM_SPR*ADDR_W-1:0] spr_addr,
  input  logic [NUM_SPR*12-1:0]     spr_data,
  input  logic [11:0]               bg_in,
  output logic [11:0]               pix_out,
  output logic                      pix_valid_out,
  output logic [NUM_SPR-1:0]        coll_flags
);

  // Stream semantics: valid-only, no backpressure. A pixel exists in a stage exactly
  // when that stage's valid bit is 1; every stage advances on every clock.

  logic [XW-1:0] sh_x   [NUM_SPR];
  logic [YW-1:0] sh_y   [NUM_SPR];
  logic [5:0]    sh_w   [NUM_SPR];
  logic [5:0]    sh_h   [NUM_SPR];
  logic          sh_vis [NUM_SPR];
  logic [XW-1:0] act_x  [NUM_SPR];
  logic [YW-1:0] act_y  [NUM_SPR];
  logic [5:0]    act_w  [NUM_SPR];
  logic [5:0]    act_h  [NUM_SPR];
  logic          act_vis[NUM_SPR];

  logic [NUM_SPR-1:0] wr_sel;

  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      wr_sel[i] = wr_en && (wr_idx == 4'(i));
    end
  end

  // A write landing on the commit edge goes straight through to the active table.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        sh_w[i]   <= '0;
        sh_h[i]   <= '0;
        sh_vis[i] <= 1'b0;
        act_x[i]   <= '0;
        act_y[i]   <= '0;
        act_w[i]   <= '0;
        act_h[i]   <= '0;
        act_vis[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NUM_SPR; i++) begin
        if (wr_sel[i]) begin
          sh_x[i]   <= wr_x;
          sh_y[i]   <= wr_y;
          sh_w[i]   <= wr_w;
          sh_h[i]   <= wr_h;
          sh_vis[i] <= wr_vis;
        end
        if (frame_start) begin
          act_x[i]   <= wr_sel[i] ? wr_x   : sh_x[i];
          act_y[i]   <= wr_sel[i] ? wr_y   : sh_y[i];
          act_w[i]   <= wr_sel[i] ? wr_w   : sh_w[i];
          act_h[i]   <= wr_sel[i] ? wr_h   : sh_h[i];
          act_vis[i] <= wr_sel[i] ? wr_vis : sh_vis[i];
        end
      end
    end
  end

  logic [NUM_SPR-1:0]        hit_n;
  logic [NUM_SPR*ADDR_W-1:0] addr_n;

  // Right/bottom edges are one bit wider than the screen so a sprite hanging off
  // the edge never wraps back to column/row 0.
  for (genvar g = 0; g < NUM_SPR; g++) begin : g_chan
    logic [XW:0]   x_end;
    logic [YW:0]   y_end;
    logic [XW-1:0] rel_c;
    logic [YW-1:0] rel_r;

    assign x_end = {1'b0, act_x[g]} + (XW+1)'(act_w[g]);
    assign y_end = {1'b0, act_y[g]} + (YW+1)'(act_h[g]);
    assign rel_c = col - act_x[g];
    assign rel_r = row - act_y[g];
    assign hit_n[g] = act_vis[g] && (act_w[g] != 6'd0) && (act_h[g] != 6'd0) &&
                      (col >= act_x[g]) && ({1'b0, col} < x_end) &&
                      (row >= act_y[g]) && ({1'b0, row} < y_end);
    assign addr_n[g*ADDR_W +: ADDR_W] =
      hit_n[g] ? (ADDR_W'(rel_r) * ADDR_W'(act_w[g]) + ADDR_W'(rel_c)) : '0;
  end

  logic [NUM_SPR-1:0] s1_hit;
  logic               s1_valid;
  logic [NUM_SPR-1:0] dly_hit  [ROM_LAT];
  logic               dly_valid[ROM_LAT];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_hit   <= '0;
      s1_valid <= 1'b0;
      spr_addr <= '0;
      for (int k = 0; k < ROM_LAT; k++) begin
        dly_hit[k]   <= '0;
        dly_valid[k] <= 1'b0;
      end
    end else begin
      s1_hit       <= hit_n;
      s1_valid     <= pix_valid_in;
      spr_addr     <= addr_n;
      dly_hit[0]   <= s1_hit;
      dly_valid[0] <= s1_valid;
      for (int k = 1; k < ROM_LAT; k++) begin
        dly_hit[k]   <= dly_hit[k-1];
        dly_valid[k] <= dly_valid[k-1];
      end
    end
  end

  logic [NUM_SPR-1:0] m_hit;
  logic               m_valid;
  logic [NUM_SPR-1:0] opaque;
  logic [11:0]        mix;
  logic [NUM_SPR-1:0] coll_hit;
  logic [NUM_SPR-1:0] coll_acc;

  assign m_hit   = dly_hit[ROM_LAT-1];
  assign m_valid = dly_valid[ROM_LAT-1];

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_key
    assign opaque[g] = m_hit[g] && (spr_data[g*12 +: 12] != KEY);
  end

  // Ascending scan: the highest-index opaque sprite wins.
  always_comb begin
    mix = bg_in;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (opaque[i]) mix = spr_data[i*12 +: 12];
    end
  end

  assign coll_hit = (m_valid && opaque[0]) ? {opaque[NUM_SPR-1:1], 1'b0} : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pix_out       <= '0;
      pix_valid_out <= 1'b0;
      coll_acc      <= '0;
      coll_flags    <= '0;
    end else begin
      pix_valid_out <= m_valid;
      if (m_valid) pix_out <= mix;
      if (frame_start) begin
        coll_flags <= coll_acc;
        coll_acc   <= coll_hit;
      end else begin
        coll_acc <= coll_acc | coll_hit;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus random scans, checked against
// a pixel-level reference model that re-applies the layering rules per scan position.
module tb_sprite_compositor;
  localparam int          N   = 8;
  localparam int          XW  = 10;
  localparam int          YW  = 9;
  localparam int          AW  = 14;
  localparam int          L   = 3;
  localparam logic [11:0] KEY = 12'h428;

  logic            clk, rstn, frame_start, pix_valid_in;
  logic [XW-1:0]   col;
  logic [YW-1:0]   row;
  logic            wr_en;
  logic [3:0]      wr_idx;
  logic [XW-1:0]   wr_x;
  logic [YW-1:0]   wr_y;
  logic [5:0]      wr_w, wr_h;
  logic            wr_vis;
  logic [N*AW-1:0] spr_addr;
  logic [N*12-1:0] spr_data;
  logic [11:0]     bg_in, pix_out;
  logic            pix_valid_out;
  logic [N-1:0]    coll_flags;

  sprite_compositor #(.NUM_SPR(N), .XW(XW), .YW(YW), .ADDR_W(AW), .ROM_LAT(L), .KEY(KEY)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .pix_valid_in(pix_valid_in),
    .col(col), .row(row), .wr_en(wr_en), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
    .wr_w(wr_w), .wr_h(wr_h), .wr_vis(wr_vis), .spr_addr(spr_addr), .spr_data(spr_data),
    .bg_in(bg_in), .pix_out(pix_out), .pix_valid_out(pix_valid_out), .coll_flags(coll_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: shadow (s*) and active (a*) tables as plain integers.
  int  sx[N], sy[N], sw[N], sh[N];
  bit  sv[N];
  int  ax[N], ay[N], aw[N], ah[N];
  bit  av[N];
  bit          rc_en[N];
  logic [11:0] rc_val[N];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 100;

  logic [11:0]     exp_q[$];
  int              exp_cyc_q[$];
  logic [N*AW-1:0] ea_hist[8];
  bit              ev_hist[8];
  logic [N*AW-1:0] da_hist[8];
  logic [11:0]     bg_hist[8];
  logic [N-1:0]    pend[16];
  logic [N-1:0]    m_acc, m_coll;
  logic [11:0]     last_pix;

  bit d_fs, d_wr, d_vis;
  int d_idx, d_x, d_y, d_w, d_h;

  function automatic logic [11:0] rom(input int i, input int a);
    logic [11:0] v;
    if (rc_en[i]) return rc_val[i];
    if ((a + i) % 5 == 0) return KEY;
    v = 12'(a * 73 + i * 411 + 291);
    if (v == KEY) v = 12'h000;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic wr(input int idx, input int x, input int y, input int w, input int h, input bit v);
    d_wr = 1; d_idx = idx; d_x = x; d_y = y; d_w = w; d_h = h; d_vis = v;
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      sx[i] = 0; sy[i] = 0; sw[i] = 0; sh[i] = 0; sv[i] = 0;
      ax[i] = 0; ay[i] = 0; aw[i] = 0; ah[i] = 0; av[i] = 0;
    end
    for (int k = 0; k < 8; k++) begin
      ev_hist[k] = 0; da_hist[k] = '0; ea_hist[k] = '0; bg_hist[k] = '0;
    end
    for (int k = 0; k < 16; k++) pend[k] = '0;
    exp_q.delete(); exp_cyc_q.delete();
    m_acc = '0; m_coll = '0; last_pix = '0;
  endtask

  // One clock: check outputs of this cycle, feed ROM/background, then drive the next pixel.
  task automatic step(input bit v, input int c, input int r);
    logic [N*AW-1:0] da, ea;
    logic [N-1:0]    ob;
    logic [11:0]     pix, bgv, e, d;
    int              a, ec;
    @(negedge clk);
    cyc++;
    if (ev_hist[(cyc-1)%8]) chk("spr_addr", spr_addr, ea_hist[(cyc-1)%8]);
    chk("coll_flags", coll_flags, m_coll);
    if (pix_valid_out) begin
      if (exp_q.size() == 0) chk("pix_valid_out", pix_valid_out, 1'b0);
      else begin
        e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
        chk("pix_out", pix_out, e);
        chk("latency", cyc, ec);
        last_pix = e;
      end
    end else begin
      chk("pix_hold", pix_out, last_pix);
      if (exp_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
        chk("pix_valid_out", pix_valid_out, 1'b1);
        void'(exp_q.pop_front()); void'(exp_cyc_q.pop_front());
      end
    end
    da_hist[cyc%8] = spr_addr;
    da = da_hist[(cyc-L)%8];
    for (int i = 0; i < N; i++) spr_data[i*12 +: 12] = rom(i, int'(da[i*AW +: AW]));
    bg_in = bg_hist[(cyc-L-1)%8];
    if (d_fs) begin
      m_coll = m_acc;
      m_acc  = pend[cyc%16];
    end else begin
      m_acc = m_acc | pend[cyc%16];
    end
    pend[cyc%16] = '0;
    frame_start = d_fs; pix_valid_in = v; col = XW'(c); row = YW'(r);
    wr_en = d_wr; wr_idx = 4'(d_idx); wr_x = XW'(d_x); wr_y = YW'(d_y);
    wr_w = 6'(d_w); wr_h = 6'(d_h); wr_vis = d_vis;
    bgv = 12'($urandom);
    bg_hist[cyc%8] = bgv;
    ea = '0; ob = '0; pix = bgv;
    for (int i = 0; i < N; i++) begin
      if (av[i] && aw[i] > 0 && ah[i] > 0 && c >= ax[i] && c < ax[i] + aw[i] &&
          r >= ay[i] && r < ay[i] + ah[i]) begin
        a = ((r - ay[i]) * aw[i] + (c - ax[i])) % (1 << AW);
        ea[i*AW +: AW] = AW'(a);
        d = rom(i, a);
        if (d != KEY) begin
          pix = d; ob[i] = 1'b1;
        end
      end
    end
    ea_hist[cyc%8] = ea; ev_hist[cyc%8] = v;
    if (v) begin
      exp_q.push_back(pix); exp_cyc_q.push_back(cyc + L + 2);
      if (ob[0]) pend[(cyc+L+1)%16] = pend[(cyc+L+1)%16] | (ob & ~N'(1));
    end
    if (d_wr && d_idx < N) begin
      sx[d_idx] = d_x; sy[d_idx] = d_y; sw[d_idx] = d_w; sh[d_idx] = d_h; sv[d_idx] = d_vis;
    end
    if (d_fs) begin
      for (int i = 0; i < N; i++) begin
        ax[i] = sx[i]; ay[i] = sy[i]; aw[i] = sw[i]; ah[i] = sh[i]; av[i] = sv[i];
      end
    end
    d_fs = 0; d_wr = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0);
  endtask

  task automatic commit();
    d_fs = 1;
    step(0, 0, 0);
  endtask

  task automatic do_reset(input bit immediate);
    rstn = 1'b0;
    #1;
    if (immediate) chk("reset_valid_now", pix_valid_out, 1'b0);
    frame_start = 0; pix_valid_in = 0; wr_en = 0; col = '0; row = '0;
    clear_model();
    repeat (2) begin
      @(negedge clk);
      cyc++;
    end
    chk("reset_pix_valid", pix_valid_out, 1'b0);
    chk("reset_pix_out", pix_out, 12'h000);
    chk("reset_spr_addr", spr_addr, '0);
    chk("reset_coll", coll_flags, '0);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 0; frame_start = 0; pix_valid_in = 0; col = '0; row = '0;
    wr_en = 0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_w = '0; wr_h = '0; wr_vis = 0;
    spr_data = '0; bg_in = '0;
    d_fs = 0; d_wr = 0; d_idx = 0; d_x = 0; d_y = 0; d_w = 0; d_h = 0; d_vis = 0;
    for (int i = 0; i < N; i++) begin
      rc_en[i] = 0; rc_val[i] = '0;
    end
    do_reset(0);

    // No sprites: background passes through.
    for (int k = 0; k < 6; k++) step(1, 10 + k, 20);
    idle(L + 3);

    // Single sprite: interior, right/bottom edge and left-edge hits/misses.
    wr(1, 100, 50, 47, 41, 1);
    step(0, 0, 0);
    commit();
    step(1, 110, 52); step(1, 146, 52); step(1, 147, 52); step(1, 100, 90);
    step(1, 100, 91); step(1, 99, 60);
    idle(L + 3);

    // Priority and colour key between sprites 1 and 3.
    rc_en[1] = 1; rc_val[1] = 12'hF00;
    rc_en[3] = 1; rc_val[3] = 12'h00F;
    wr(3, 105, 52, 10, 10, 1);
    commit();
    step(1, 110, 55);
    idle(L + 3);
    rc_val[3] = KEY;
    step(1, 110, 55);
    idle(L + 3);

    // Mid-frame write stays invisible until the next commit.
    rc_en[2] = 1; rc_val[2] = 12'h0AA;
    wr(2, 200, 100, 8, 8, 1);
    step(0, 0, 0);
    step(1, 202, 102);
    idle(L + 3);
    commit();
    step(1, 202, 102);
    idle(L + 3);

    // Collision of sprite 0 with sprite 2, reported one frame later, then cleared.
    rc_en[0] = 1; rc_val[0] = 12'hFFF;
    wr(0, 300, 200, 4, 4, 1);
    step(0, 0, 0);
    wr(2, 301, 201, 4, 4, 1);
    commit();
    step(1, 302, 202);
    idle(L + 3);
    chk("coll_during_frame", coll_flags, '0);
    commit();
    @(posedge clk);
    #1;
    chk("coll_after_frame", coll_flags, 8'b0000_0100);
    idle(4);
    commit();
    idle(3);

    // Right-screen-edge sprite must not wrap to column 5.
    rc_en[4] = 1; rc_val[4] = 12'h777;
    wr(4, 1020, 0, 40, 10, 1);
    commit();
    step(1, 5, 3); step(1, 1023, 3); step(1, 1019, 3);
    idle(L + 3);
    for (int i = 0; i < N; i++) rc_en[i] = 0;

    // Random tables, writes, commits and scans.
    for (int f = 0; f < 40; f++) begin
      for (int k = 0; k < 45; k++) begin
        if ($urandom_range(0, 7) == 0)
          wr($urandom_range(0, 15), $urandom_range(0, 80), $urandom_range(0, 80),
             $urandom_range(0, 40), $urandom_range(0, 40), $urandom_range(0, 5) != 0);
        if ($urandom_range(0, 29) == 0) d_fs = 1;
        if ($urandom_range(0, 9) == 0)
          step($urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 511));
        else
          step($urandom_range(0, 3) != 0, $urandom_range(0, 127), $urandom_range(0, 127));
      end
      commit();
    end

    // Reset in the middle of a busy scan drops everything in flight.
    for (int k = 0; k < 4; k++) step(1, $urandom_range(0, 127), $urandom_range(0, 127));
    @(negedge clk);
    cyc++;
    do_reset(1);
    for (int k = 0; k < 8; k++) step(1, $urandom_range(0, 127), $urandom_range(0, 127));
    idle(L + 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
